// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream and imem write bus of the instruction-memory
// loader.
//   byte_valid/byte_data/byte_ready : inbound boot-link byte stream (valid/ready)
//   imem_we/imem_waddr/imem_wdata   : one-cycle write pulses into instruction memory
// The master modport is the loader side; the slave modport is the link/memory side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream, assembles
// little-endian 32-bit words, writes each one to instruction memory with a
// single-cycle strobe, verifies the trailing XOR checksum and then raises
// loader_done to release instruction fetch.
//
// Frame: LEN_LO LEN_HI (word count N), N*4 data bytes, CSUM (XOR of all
// preceding frame bytes).
//
// Ports:
//   clk           clock
//   rst           asynchronous active-low reset
//   bus           imem_loader_if.master (byte stream in, imem write pulses out)
//   reload        one-cycle pulse: abort / re-arm for a new frame
//   loader_done   sticky: image written and checksum good
//   load_error    sticky: frame rejected
//   err_code      0 none, 1 checksum, 2 bad length, 3 timeout
//   words_written words written in the current frame
//
// Optional build macro IMEM_LOADER_TIMEOUT_EN adds a mid-frame idle timeout
// of TIMEOUT_CYCLES cycles (err_code 3). Without it the loader waits forever.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_loader_if.master        bus,
  input  logic                 reload,
  output logic                 loader_done,
  output logic                 load_error,
  output logic [1:0]           err_code,
  output logic [15:0]          words_written
);

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS_L = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;       // first three bytes of the word in flight
  logic [15:0] index_q, index_d;     // doubles as words_written
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  logic [31:0] idle_q, idle_d;
`endif

  logic        ready_state;
  logic        byte_ready;
  logic        accept;
  logic [15:0] len_full;

  assign ready_state = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
  // Gating with rst keeps ready low for the whole reset interval; gating with
  // reload guarantees a byte offered alongside reload is never consumed.
  assign byte_ready  = rst & ~reload & ready_state;
  assign accept      = bus.byte_valid & byte_ready;
  assign len_full    = {bus.byte_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    index_d    = index_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
`ifdef IMEM_LOADER_TIMEOUT_EN
    idle_d     = idle_q;
`endif

    if (reload) begin
      // Partial word and any write that would have followed are dropped.
      state_d    = S_LEN_LO;
      byte_cnt_d = 2'd0;
      word_d     = 24'd0;
      index_d    = 16'd0;
      csum_d     = 8'd0;
      waddr_d    = BASE_ADDR;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = 2'd0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      idle_d     = 32'd0;
`endif
    end else begin
      case (state_q)
        S_LEN_LO: if (accept) begin
          len_d[7:0] = bus.byte_data;
          csum_d     = csum_q ^ bus.byte_data;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: if (accept) begin
          len_d[15:8] = bus.byte_data;
          csum_d      = csum_q ^ bus.byte_data;
          byte_cnt_d  = 2'd0;
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_WORDS_L) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: if (accept) begin
          csum_d     = csum_q ^ bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {bus.byte_data, word_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {bus.byte_data, word_q};
            waddr_d = BASE_ADDR + {14'd0, index_q, 2'b00};
            index_d = index_q + 16'd1;
            if (index_q == len_q - 16'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: if (accept) begin
          if (bus.byte_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
        default: ;  // S_DONE / S_ERR hold until reload
      endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
      // Only mid-frame states count idle cycles; waiting for LEN_LO is legal.
      if (state_q == S_LEN_HI || state_q == S_DATA || state_q == S_CSUM) begin
        if (accept) begin
          idle_d = 32'd0;
        end else if (idle_q >= TIMEOUT_LAST) begin
          idle_d     = 32'd0;
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end else begin
        idle_d = 32'd0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LEN_LO;
      len_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 24'd0;
      index_q    <= 16'd0;
      csum_q     <= 8'd0;
      we_q       <= 1'b0;
      waddr_q    <= BASE_ADDR;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      idle_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      index_q    <= index_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign loader_done    = done_q;
  assign load_error     = err_q;
  assign err_code       = err_code_q;
  assign words_written  = index_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader. Each scenario
// task drives its own stimulus and compares outputs against hand-computed
// values; a negedge monitor logs every imem write pulse.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        reload;
  logic        loader_done;
  logic        load_error;
  logic [1:0]  err_code;
  logic [15:0] words_written;

  imem_loader_if bus();

  imem_loader #(
    .BASE_ADDR      (32'h0000_0000),
    .MAX_WORDS      (256),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .reload        (reload),
    .loader_done   (loader_done),
    .load_error    (load_error),
    .err_code      (err_code),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-pulse log
  int          wr_total = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_total < 64) begin
        wr_addr[wr_total] = bus.imem_waddr;
        wr_data[wr_total] = bus.imem_wdata;
        wr_cyc[wr_total]  = cyc;
      end
      wr_total = wr_total + 1;
    end
  end

  // Reference frame: 2 words 0x00000013, 0x00500093; checksum 0xD2.
  logic [7:0] frame1 [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h50, 8'h00, 8'hD2};
  int         gaps   [11] = '{0, 3, 5, 1, 0, 2, 4, 5, 0, 1, 3};
  int         acc_cyc [16];

  // Offers one byte (called just after a posedge) and returns #1 after the
  // edge on which it was accepted; acc_cyc index records that edge.
  task automatic send_byte(input logic [7:0] b, input int slot);
    bit got;
    got = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk_cnt++;
      $display("FAIL send_byte_timeout: byte_ready stayed %b, required 1", bus.byte_ready);
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    if (slot >= 0 && slot < 16) acc_cyc[slot] = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    reload = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL reset_byte_ready: got %b, required 0", bus.byte_ready); else pass_cnt++;
    chk_cnt++; if (bus.imem_we !== 1'b0) $display("FAIL reset_imem_we: got %b, required 0", bus.imem_we); else pass_cnt++;
    chk_cnt++; if (bus.imem_waddr !== 32'h0 || bus.imem_wdata !== 32'h0)
                 $display("FAIL reset_addr_data: got %h/%h, required 0/0", bus.imem_waddr, bus.imem_wdata); else pass_cnt++;
    chk_cnt++; if ({loader_done, load_error, err_code} !== 4'b0)
                 $display("FAIL reset_status: got done=%b err=%b code=%0d, required 0/0/0", loader_done, load_error, err_code); else pass_cnt++;
    chk_cnt++; if (words_written !== 16'd0) $display("FAIL reset_words: got %0d, required 0", words_written); else pass_cnt++;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.byte_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", bus.byte_ready); else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    int base;
    base = wr_total;
    for (int i = 0; i < 10; i++) send_byte(frame1[i], i);
    chk_cnt++; if (loader_done !== 1'b0) $display("FAIL good_done_early: got %b, required 0", loader_done); else pass_cnt++;
    send_byte(frame1[10], 10);
    @(negedge clk);
    chk_cnt++; if (wr_total - base !== 2) $display("FAIL good_write_count: got %0d, required 2", wr_total - base); else pass_cnt++;
    chk_cnt++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h0000_0013)
                 $display("FAIL good_write0: got %h/%h, required 00000000/00000013", wr_addr[base], wr_data[base]); else pass_cnt++;
    chk_cnt++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h0050_0093)
                 $display("FAIL good_write1: got %h/%h, required 00000004/00500093", wr_addr[base+1], wr_data[base+1]); else pass_cnt++;
    chk_cnt++; if (wr_cyc[base] !== acc_cyc[5] || wr_cyc[base+1] !== acc_cyc[9])
                 $display("FAIL good_write_timing: got cyc %0d/%0d, required %0d/%0d", wr_cyc[base], wr_cyc[base+1], acc_cyc[5], acc_cyc[9]); else pass_cnt++;
    chk_cnt++; if (loader_done !== 1'b1 || load_error !== 1'b0 || err_code !== 2'd0)
                 $display("FAIL good_status: got done=%b err=%b code=%0d, required 1/0/0", loader_done, load_error, err_code); else pass_cnt++;
    chk_cnt++; if (words_written !== 16'd2) $display("FAIL good_words: got %0d, required 2", words_written); else pass_cnt++;
    chk_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL good_ready_after_done: got %b, required 0", bus.byte_ready); else pass_cnt++;
    $display("good frame: %0d writes, done=%b", wr_total - base, loader_done);
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_csum();
    int base;
    pulse_reload();
    @(negedge clk);
    chk_cnt++; if (loader_done !== 1'b0 || words_written !== 16'd0)
                 $display("FAIL reload_clears: got done=%b words=%0d, required 0/0", loader_done, words_written); else pass_cnt++;
    @(posedge clk);
    #1;
    base = wr_total;
    for (int i = 0; i < 10; i++) send_byte(frame1[i], i);
    send_byte(8'hD3, 10);
    @(negedge clk);
    chk_cnt++; if (wr_total - base !== 2) $display("FAIL csum_write_count: got %0d, required 2", wr_total - base); else pass_cnt++;
    chk_cnt++; if (load_error !== 1'b1 || err_code !== 2'd1 || loader_done !== 1'b0)
                 $display("FAIL csum_status: got err=%b code=%0d done=%b, required 1/1/0", load_error, err_code, loader_done); else pass_cnt++;
    chk_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL csum_ready: got %b, required 0", bus.byte_ready); else pass_cnt++;
    $display("bad csum frame: err_code=%0d", err_code);
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_len();
    logic [7:0] lens [4];
    int base;
    lens = '{8'h00, 8'h00, 8'h01, 8'h01};
    for (int t = 0; t < 2; t++) begin
      pulse_reload();
      base = wr_total;
      send_byte(lens[2*t], 0);
      send_byte(lens[2*t+1], 1);
      @(negedge clk);
      chk_cnt++; if (load_error !== 1'b1 || err_code !== 2'd2)
                   $display("FAIL badlen%0d_status: got err=%b code=%0d, required 1/2", t, load_error, err_code); else pass_cnt++;
      chk_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL badlen%0d_ready: got %b, required 0", t, bus.byte_ready); else pass_cnt++;
      idle(4);
      chk_cnt++; if (wr_total - base !== 0) $display("FAIL badlen%0d_writes: got %0d, required 0", t, wr_total - base); else pass_cnt++;
      $display("bad length %02h%02h: err_code=%0d", lens[2*t+1], lens[2*t], err_code);
    end
  endtask

  task automatic test_gaps();
    int base;
    pulse_reload();
    base = wr_total;
    for (int i = 0; i < 10; i++) begin
      idle(gaps[i]);
      send_byte(frame1[i], i);
    end
    idle(gaps[10]);
    chk_cnt++; if (loader_done !== 1'b0) $display("FAIL gaps_done_early: got %b, required 0", loader_done); else pass_cnt++;
    send_byte(frame1[10], 10);
    @(negedge clk);
    chk_cnt++; if (loader_done !== 1'b1) $display("FAIL gaps_done: got %b, required 1", loader_done); else pass_cnt++;
    chk_cnt++; if (wr_total - base !== 2 || wr_data[base] !== 32'h13 || wr_data[base+1] !== 32'h0050_0093 || wr_addr[base+1] !== 32'h4)
                 $display("FAIL gaps_writes: got n=%0d %h %h@%h, required 2 00000013 00500093@00000004", wr_total - base, wr_data[base], wr_data[base+1], wr_addr[base+1]); else pass_cnt++;
    chk_cnt++; if (wr_cyc[base] !== acc_cyc[5] || wr_cyc[base+1] !== acc_cyc[9])
                 $display("FAIL gaps_write_timing: got %0d/%0d, required %0d/%0d", wr_cyc[base], wr_cyc[base+1], acc_cyc[5], acc_cyc[9]); else pass_cnt++;
    $display("gapped frame: %0d writes, done=%b", wr_total - base, loader_done);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reload_mid();
    int base;
    pulse_reload();
    base = wr_total;
    for (int i = 0; i < 8; i++) send_byte(frame1[i], i);   // len + 6 data bytes
    // Offer a byte together with reload: it must be refused.
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    reload = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL reload_byte_ready: got %b, required 0", bus.byte_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    reload = 1'b0;
    bus.byte_valid = 1'b0;
    idle(3);
    chk_cnt++; if (wr_total - base !== 1) $display("FAIL reload_stale_pulse: got %0d writes, required 1", wr_total - base); else pass_cnt++;
    chk_cnt++; if (words_written !== 16'd0 || bus.byte_ready !== 1'b1)
                 $display("FAIL reload_rearm: got words=%0d ready=%b, required 0/1", words_written, bus.byte_ready); else pass_cnt++;
    base = wr_total;
    for (int i = 0; i < 11; i++) send_byte(frame1[i], i);
    @(negedge clk);
    chk_cnt++; if (wr_total - base !== 2 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h13 || wr_data[base+1] !== 32'h0050_0093)
                 $display("FAIL reload_resend_writes: got n=%0d %h:%h %h, required 2 00000000:00000013 00500093", wr_total - base, wr_addr[base], wr_data[base], wr_data[base+1]); else pass_cnt++;
    chk_cnt++; if (loader_done !== 1'b1) $display("FAIL reload_resend_done: got %b, required 1", loader_done); else pass_cnt++;
    $display("reload mid-frame then resend: %0d writes, done=%b", wr_total - base, loader_done);
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    pulse_reload();
    for (int i = 0; i < 5; i++) send_byte(frame1[i], i);   // len + 3 data bytes
`ifdef IMEM_LOADER_TIMEOUT_EN
    repeat (49) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (load_error !== 1'b0) $display("FAIL timeout_early: got err=%b, required 0", load_error); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (load_error !== 1'b1 || err_code !== 2'd3)
                 $display("FAIL timeout_status: got err=%b code=%0d, required 1/3", load_error, err_code); else pass_cnt++;
    $display("timeout: err_code=%0d", err_code);
`else
    idle(1000);
    @(negedge clk);
    chk_cnt++; if (bus.byte_ready !== 1'b1 || load_error !== 1'b0 || err_code !== 2'd0)
                 $display("FAIL no_timeout: got ready=%b err=%b code=%0d, required 1/0/0", bus.byte_ready, load_error, err_code); else pass_cnt++;
    $display("no timeout after 1000 idle cycles: ready=%b", bus.byte_ready);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_gaps();
    test_reload_mid();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
